// File: rtl/hd44780_bus_responder_if.sv
// hd44780_bus_responder_if: 8-bit HD44780 parallel bus between host and controller
interface hd44780_bus_responder_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data_i;
    logic [7:0] lcd_data_o;
    logic       lcd_data_oe;
    modport master (output lcd_rs, lcd_rw, lcd_e, lcd_data_i, input lcd_data_o, lcd_data_oe);
    modport slave (input lcd_rs, lcd_rw, lcd_e, lcd_data_i, output lcd_data_o, lcd_data_oe);
endinterface

// File: rtl/hd44780_bus_responder.sv
// hd44780_bus_responder: controller-side HD44780 model with DDRAM/CGRAM, AC, busy flag and debug port
module hd44780_bus_responder #(
    parameter int BUSY_CYCLES  = 50,
    parameter int CLEAR_CYCLES = 100,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    hd44780_bus_responder_if.slave bus,
    output logic                   busy_o,
    output logic [6:0]             ac_o,
    output logic [2:0]             disp_ctrl_o,
    output logic [1:0]             entry_o,
    output logic [2:0]             func_o,
    input  logic                   dbg_sel_i,
    input  logic [6:0]             dbg_addr_i,
    output logic [7:0]             dbg_data_o,
    output logic [15:0]            cmd_count_o,
    output logic                   viol_o
);
    localparam int CLR = CLEAR_CYCLES < 80 ? 80 : CLEAR_CYCLES;
    localparam int CW  = $clog2((CLR > BUSY_CYCLES ? CLR : BUSY_CYCLES) + 1);
    typedef enum logic [1:0] {IDLE, CLEAR, EXEC} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic cg;
    logic [SYNC_STAGES-1:0] e_sh, rs_sh, rw_sh;
    logic [SYNC_STAGES-1:0][7:0] d_sh;
    logic e_q, rs_l, rw_l;
    logic [7:0] d_l;
    logic [1:0] e_len;
    logic [7:0] ddram [80];
    logic [7:0] cgram [64];
    logic e_s, rs_s, rw_s, fall, wr, wr_ok, dd_ok;
    logic [6:0] dd_idx, ac_step, ac_shift;
    logic [7:0] ram_q;

    // Next AC for a +/-1 step, honouring the two-line DDRAM gaps and CGRAM wrap
    function automatic logic [6:0] step(input logic [6:0] a, input logic inc, input logic c, input logic n);
        if (c) return {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
        if (n) return inc ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
                          : (a == 7'h40 ? 7'h27 : a == 7'h00 ? 7'h67 : a - 7'd1);
        return inc ? (a == 7'h4F ? 7'h00 : a + 7'd1) : (a == 7'h00 ? 7'h4F : a - 7'd1);
    endfunction

    assign e_s      = e_sh[SYNC_STAGES-1];
    assign rs_s     = rs_sh[SYNC_STAGES-1];
    assign rw_s     = rw_sh[SYNC_STAGES-1];
    assign fall     = e_q & ~e_s;
    assign wr       = fall & ~rw_l;
    assign wr_ok    = wr & (state == IDLE);
    assign busy_o   = state != IDLE;
    assign ac_step  = step(ac_o, entry_o[1], cg, func_o[1]);
    assign ac_shift = step(ac_o, d_l[2], cg, func_o[1]);
    assign dd_ok    = func_o[1] ? (ac_o <= 7'h27 || (ac_o >= 7'h40 && ac_o <= 7'h67)) : ac_o <= 7'h4F;
    assign dd_idx   = (func_o[1] && ac_o >= 7'h40) ? ac_o - 7'd24 : ac_o;
    assign ram_q    = cg ? cgram[ac_o[5:0]] : dd_ok ? ddram[dd_idx] : 8'h00;
    assign bus.lcd_data_oe = e_s & rw_s;
    assign bus.lcd_data_o  = (e_s & rw_s) ? (rs_s ? ram_q : {busy_o, ac_o}) : 8'h00;
    assign dbg_data_o = dbg_sel_i ? cgram[dbg_addr_i[5:0]] : dbg_addr_i < 7'd80 ? ddram[dbg_addr_i] : 8'h00;

    always_ff @(posedge clk) begin
        if (state == CLEAR && cnt < CW'(80)) ddram[cnt[6:0]] <= 8'h20;
        else if (wr_ok && rs_l && !cg && dd_ok) ddram[dd_idx] <= d_l;
        if (wr_ok && rs_l && cg) cgram[ac_o[5:0]] <= d_l;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLEAR;
            cnt         <= '0;
            cg          <= 1'b0;
            ac_o        <= '0;
            disp_ctrl_o <= 3'b000;
            entry_o     <= 2'b10;
            func_o      <= 3'b100;
            cmd_count_o <= '0;
            viol_o      <= 1'b0;
            e_sh        <= '0;
            rs_sh       <= '0;
            rw_sh       <= '0;
            d_sh        <= '0;
            e_q         <= 1'b0;
            rs_l        <= 1'b0;
            rw_l        <= 1'b0;
            d_l         <= '0;
            e_len       <= '0;
        end else begin
            e_sh  <= {e_sh[SYNC_STAGES-2:0], bus.lcd_e};
            rs_sh <= {rs_sh[SYNC_STAGES-2:0], bus.lcd_rs};
            rw_sh <= {rw_sh[SYNC_STAGES-2:0], bus.lcd_rw};
            d_sh  <= {d_sh[SYNC_STAGES-2:0], bus.lcd_data_i};
            e_q   <= e_s;
            // Hold the bus values from the last cycle E was high for use at the falling edge
            if (e_s) begin
                rs_l  <= rs_s;
                rw_l  <= rw_s;
                d_l   <= d_sh[SYNC_STAGES-1];
                e_len <= e_len == 2'd2 ? e_len : e_len + 2'd1;
            end else e_len <= '0;
            if (fall && (e_len < 2'd2 || (wr && busy_o))) viol_o <= 1'b1;
            if (fall && rw_l && rs_l) ac_o <= ac_step;
            case (state)
                CLEAR: begin
                    if (cnt == CW'(CLR - 1)) begin
                        state      <= IDLE;
                        ac_o       <= '0;
                        cg         <= 1'b0;
                        entry_o[1] <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                EXEC: begin
                    if (cnt == '0) state <= IDLE;
                    else cnt <= cnt - 1'b1;
                end
                IDLE: if (wr) begin
                    cmd_count_o <= cmd_count_o + 16'(cmd_count_o != 16'hFFFF);
                    state       <= EXEC;
                    cnt         <= CW'(BUSY_CYCLES - 1);
                    if (rs_l) ac_o <= ac_step;
                    else if (d_l[7]) begin cg <= 1'b0; ac_o <= d_l[6:0]; end
                    else if (d_l[6]) begin cg <= 1'b1; ac_o <= {1'b0, d_l[5:0]}; end
                    else if (d_l[5]) func_o <= d_l[4:2];
                    else if (d_l[4]) begin if (!d_l[3]) ac_o <= ac_shift; end
                    else if (d_l[3]) disp_ctrl_o <= d_l[2:0];
                    else if (d_l[2]) entry_o <= d_l[1:0];
                    else if (d_l[1]) begin cg <= 1'b0; ac_o <= '0; end
                    else if (d_l[0]) begin state <= CLEAR; cnt <= '0; end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hd44780_bus_responder.sv
// tb_hd44780_bus_responder: randomized scoreboard bench against a behavioural HD44780 model
module tb_hd44780_bus_responder;
    localparam int SYNC = 2;
    logic clk = 1'b0, reset = 1'b0;
    logic dbg_sel = 1'b0;
    logic [6:0] dbg_addr = '0;
    logic busy, viol;
    logic [6:0] ac;
    logic [2:0] disp, func;
    logic [1:0] entry;
    logic [7:0] dbg_data;
    logic [15:0] cmd_count;
    int checks = 0, failures = 0;

    hd44780_bus_responder_if bus ();
    hd44780_bus_responder #(.BUSY_CYCLES(50), .CLEAR_CYCLES(100), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy_o(busy), .ac_o(ac), .disp_ctrl_o(disp),
        .entry_o(entry), .func_o(func), .dbg_sel_i(dbg_sel), .dbg_addr_i(dbg_addr),
        .dbg_data_o(dbg_data), .cmd_count_o(cmd_count), .viol_o(viol));

    always #5 clk = ~clk;

    logic [7:0] ddm [80];
    logic [7:0] cgm [64];
    bit cgv [64];
    int m_ac, m_count;
    bit m_cg, m_viol;
    logic [1:0] m_entry;
    logic [2:0] m_disp, m_func;
    logic [31:0] sb [$];
    logic [7:0] rdq [$];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        failures++;
        $display("FAIL %s got=missing exp=present", name);
    endtask

    function automatic logic [31:0] snap();
        return {7'(m_ac), m_disp, m_entry, m_func, 16'(m_count), m_viol};
    endfunction

    // Linear screen position (0..79) of an AC value, or -1 outside the visible map
    function automatic int dd_index(int a);
        if (m_func[1]) return a < 40 ? a : (a >= 64 && a < 104) ? a - 24 : -1;
        return a < 80 ? a : -1;
    endfunction

    function automatic int step(int a, bit inc);
        int i = dd_index(a);
        if (m_cg) return (a + (inc ? 1 : 63)) % 64;
        if (i < 0) return (a + (inc ? 1 : 127)) % 128;
        i = (i + (inc ? 1 : 79)) % 80;
        return (m_func[1] && i >= 40) ? i + 24 : i;
    endfunction

    function automatic logic [7:0] ram_read();
        if (m_cg) return cgm[m_ac];
        return dd_index(m_ac) >= 0 ? ddm[dd_index(m_ac)] : 8'h00;
    endfunction

    task automatic model_reset();
        foreach (ddm[i]) ddm[i] = 8'h20;
        m_ac = 0; m_cg = 0; m_entry = 2'b10; m_disp = 3'b000; m_func = 3'b100; m_count = 0; m_viol = 0;
    endtask

    task automatic model_write(bit rs, logic [7:0] d);
        m_count = m_count == 65535 ? m_count : m_count + 1;
        if (rs) begin
            if (m_cg) begin cgm[m_ac] = d; cgv[m_ac] = 1; end
            else if (dd_index(m_ac) >= 0) ddm[dd_index(m_ac)] = d;
            m_ac = step(m_ac, m_entry[1]);
        end
        else if (d >= 8'h80) begin m_cg = 0; m_ac = int'(d) - 128; end
        else if (d >= 8'h40) begin m_cg = 1; m_ac = int'(d) - 64; end
        else if (d >= 8'h20) m_func = d[4:2];
        else if (d >= 8'h10) begin if (!d[3]) m_ac = step(m_ac, d[2]); end
        else if (d >= 8'h08) m_disp = d[2:0];
        else if (d >= 8'h04) m_entry = d[1:0];
        else if (d >= 8'h02) begin m_cg = 0; m_ac = 0; end
        else if (d == 8'h01) begin
            foreach (ddm[i]) ddm[i] = 8'h20;
            m_cg = 0; m_ac = 0; m_entry[1] = 1;
        end
    endtask

    task automatic strobe(bit rs, bit rw, logic [7:0] d);
        @(negedge clk);
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data_i = d; bus.lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_e = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        bus.lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        if (busy !== 1'b0) fail("idle_timeout");
    endtask

    task automatic write(bit rs, logic [7:0] d);
        wait_idle();
        model_write(rs, d);
        sb.push_back(snap());
        strobe(rs, 1'b0, d);
    endtask

    task automatic viol_write(bit rs, logic [7:0] d);
        logic [31:0] t;
        strobe(rs, 1'b0, d);
        m_viol = 1;
        if (sb.size() > 0) begin t = sb.pop_back(); t[0] = 1'b1; sb.push_back(t); end
    endtask

    task automatic read(bit rs, bit bsy);
        rdq.push_back(rs ? ram_read() : {bsy, 7'(m_ac)});
        strobe(rs, 1'b1, 8'h00);
        if (rs) m_ac = step(m_ac, m_entry[1]);
    endtask

    task automatic dbg_chk(bit sel, int addr, logic [7:0] exp, string name);
        dbg_sel = sel; dbg_addr = 7'(addr);
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sb.delete(); rdq.delete();
        repeat (3) @(negedge clk);
        model_reset();
        sb.push_back(snap());
        reset = 1'b1;
    endtask

    task automatic busy_count();
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("clear_busy_cycles", n, 100);
    endtask

    initial begin
        logic bp = 1'b0, op = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && bp && !busy) begin
                if (sb.size() == 0) fail("state_scoreboard");
                else chk("state_on_idle", {ac, disp, entry, func, cmd_count, viol}, sb.pop_front());
            end
            if (bus.lcd_data_oe && !op) begin
                if (rdq.size() == 0) fail("read_scoreboard");
                else chk("read_data", 32'(bus.lcd_data_o), 32'(rdq.pop_front()));
            end
            bp = busy; op = bus.lcd_data_oe;
        end
    end

    initial begin
        int n;
        bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_i = '0;
        do_reset();
        busy_count();
        dbg_chk(0, 0, 8'h20, "dd0_clear");
        dbg_chk(0, 40, 8'h20, "dd40_clear");
        dbg_chk(0, 79, 8'h20, "dd79_clear");
        chk("ac_after_clear", ac, 0);
        write(0, 8'h38); write(0, 8'h0C); write(0, 8'h06); write(0, 8'h80);
        write(1, 8'h48); write(1, 8'h49); wait_idle();
        chk("func_set", func, 3'b110);
        chk("disp_ctrl", disp, 3'b100);
        chk("entry_mode", entry, 2'b10);
        dbg_chk(0, 0, 8'h48, "dd0_H");
        dbg_chk(0, 1, 8'h49, "dd1_I");
        chk("ac_after_HI", ac, 7'h02);
        chk("count_six", cmd_count, 6);
        write(0, 8'hA7); write(1, 8'h41); write(1, 8'h42); wait_idle();
        dbg_chk(0, 39, 8'h41, "dd39_line_end");
        dbg_chk(0, 40, 8'h42, "dd40_line2");
        chk("ac_line_wrap", ac, 7'h41);
        write(0, 8'h40);
        for (int i = 0; i < 8; i++) write(1, 8'(i));
        wait_idle();
        for (int i = 0; i < 8; i++) dbg_chk(1, i, 8'(i), "cgram_glyph");
        chk("ac_cgram8", ac, 7'h08);
        for (int i = 0; i < 56; i++) write(1, 8'($urandom));
        wait_idle();
        chk("ac_cgram_wrap", ac, 7'h00);
        write(0, 8'h85); write(1, 8'h33);
        repeat (5) @(negedge clk);
        viol_write(1, 8'h77);
        read(0, 1'b1);
        wait_idle();
        chk("viol_sticky", viol, 1);
        chk("count_after_viol", cmd_count, 16'(m_count));
        dbg_chk(0, 6, 8'h20, "dd6_unchanged");
        dbg_chk(0, 5, 8'h33, "dd5_written");
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 10))
                0, 1, 2: write(1, 8'($urandom));
                3:       write(0, 8'h80 | 8'($urandom_range(0, 127)));
                4:       write(0, 8'h40 | 8'($urandom_range(0, 63)));
                5:       write(0, 8'h04 | 8'($urandom_range(0, 3)));
                6:       write(0, 8'h20 | 8'($urandom_range(0, 31)));
                7:       write(0, 8'h10 | 8'($urandom_range(0, 15)));
                8:       begin wait_idle(); read(0, 1'b0); end
                9:       begin
                    wait_idle();
                    if (m_cg && !cgv[m_ac]) read(0, 1'b0);
                    else read(1, 1'b0);
                end
                default: write(0, $urandom_range(0, 3) == 0 ? 8'h01 : 8'h02 | 8'($urandom_range(0, 1)));
            endcase
        end
        wait_idle();
        for (int i = 0; i < 80; i++) dbg_chk(0, i, ddm[i], "ddram_final");
        for (int i = 0; i < 64; i++) if (cgv[i]) dbg_chk(1, i, cgm[i], "cgram_final");
        do_reset();
        repeat (30) @(negedge clk);
        chk("busy_mid_clear", busy, 1);
        do_reset();
        busy_count();
        chk("viol_after_reset", viol, 0);
        chk("count_after_reset", cmd_count, 0);
        dbg_chk(0, 0, 8'h20, "dd0_reclear");
        for (int i = 0; i < 64; i++) if (cgv[i]) dbg_chk(1, i, cgm[i], "cgram_kept");
        n = 0;
        while ((sb.size() != 0 || rdq.size() != 0) && n < 500) begin @(negedge clk); n++; end
        if (sb.size() != 0 || rdq.size() != 0) fail("scoreboard_drain");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
